// File: rtl/nucleus_pkg.sv
// Shared types and default constants for the Nucleus marble puzzle.
package nucleus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_FALL,
    S_LAND,
    S_DONE
  } state_t;

  localparam logic BLUE = 1'b1;
  localparam logic RED  = 1'b0;

  localparam int DEF_BITS       = 3;
  localparam int DEF_BLUE_BALLS = 10;
  localparam int DEF_RED_BALLS  = 10;
  localparam int DEF_TRAY_W     = 20;

endpackage

// File: rtl/nucleus_bit_chain.sv
// Chain of bit flip-flops the ball ripples through; bit 0 is hit first.
module nucleus_bit_chain #(
  parameter int BITS = 3,
  parameter int PW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          toggle,
  input  logic [PW-1:0] pos,
  output logic          old_bit,
  output logic          last
);

  logic [BITS-1:0] bits;

  // Value before this cycle's toggle decides whether the ball exits or ripples on.
  assign old_bit = bits[pos];
  assign last    = (pos == PW'(BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits <= '0;
    end else if (toggle) begin
      bits[pos] <= ~bits[pos];
    end
  end

endmodule

// File: rtl/nucleus_puzzle.sv
// Nucleus puzzle top: run FSM, blue/red reservoirs and the collection tray.
module nucleus_puzzle
  import nucleus_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int BLUE_BALLS = DEF_BLUE_BALLS,
  parameter int RED_BALLS  = DEF_RED_BALLS,
  parameter int TRAY_W     = DEF_TRAY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              stopped,
  output logic [TRAY_W-1:0] tray,
  output logic [4:0]        tray_size
);

  localparam int PW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int RMAX = (BLUE_BALLS > RED_BALLS) ? BLUE_BALLS : RED_BALLS;
  localparam int RW   = $clog2(RMAX + 2);
  localparam logic [4:0] TRAY_MAX  = 5'(TRAY_W);
  localparam logic [4:0] TRAY_LAST = 5'(TRAY_W - 1);

  state_t          state, state_d;
  logic            req_colour;
  logic            colour;
  logic [PW-1:0]   pos;
  logic [RW-1:0]   blue_left, red_left;

  logic req_empty;
  logic chain_toggle, old_bit, last_bit;
  logic req_first, load_ball, advance, do_land;

  assign req_empty = (req_colour == BLUE) ? (blue_left == '0) : (red_left == '0);

  nucleus_bit_chain #(
    .BITS (BITS),
    .PW   (PW)
  ) u_chain (
    .clk     (clk),
    .rst     (rst),
    .toggle  (chain_toggle),
    .pos     (pos),
    .old_bit (old_bit),
    .last    (last_bit)
  );

  always_comb begin
    state_d      = state;
    chain_toggle = 1'b0;
    req_first    = 1'b0;
    load_ball    = 1'b0;
    advance      = 1'b0;
    do_land      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          req_first = 1'b1;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (req_empty) begin
          state_d = S_DONE;
        end else begin
          load_ball = 1'b1;
          state_d   = S_FALL;
        end
      end
      S_FALL: begin
        chain_toggle = 1'b1;
        if (!old_bit)      state_d = S_LAND;
        else if (last_bit) state_d = S_DONE;  // carry-out: interceptor swallows the ball
        else               advance = 1'b1;
      end
      S_LAND: begin
        do_land = 1'b1;
        state_d = (tray_size == TRAY_LAST) ? S_DONE : S_RELEASE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_colour <= BLUE;
      colour     <= BLUE;
      pos        <= '0;
      blue_left  <= RW'(BLUE_BALLS);
      red_left   <= RW'(RED_BALLS);
      tray       <= '0;
      tray_size  <= '0;
      stopped    <= 1'b0;
    end else begin
      if (req_first) req_colour <= BLUE;
      if (load_ball) begin
        colour <= req_colour;
        pos    <= '0;
        if (req_colour == BLUE) blue_left <= blue_left - RW'(1);
        else                    red_left  <= red_left - RW'(1);
      end
      if (advance) pos <= pos + PW'(1);
      if (do_land && (tray_size < TRAY_MAX)) begin
        tray[tray_size] <= colour;
        tray_size       <= tray_size + 5'd1;
        // Even exit position requests blue next, odd requests red.
        req_colour      <= pos[0] ? RED : BLUE;
      end
      if (state_d == S_DONE) stopped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nucleus_puzzle.sv
// Randomized scoreboard bench for nucleus_puzzle across four parameter sets.
module tb_nucleus_puzzle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst_v   [4];
  logic        start_v [4];
  logic        stop_a  [4];
  logic [19:0] tray_a  [4];
  logic [4:0]  size_a  [4];
  logic [19:0] tray0, tray1, tray2;
  logic [7:0]  tray3;

  int cfg_bits [4];
  int cfg_blue [4];
  int cfg_red  [4];
  int cfg_tray [4];

  nucleus_puzzle u_def (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
    .stopped(stop_a[0]), .tray(tray0), .tray_size(size_a[0])
  );
  nucleus_puzzle #(.RED_BALLS(1)) u_red1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
    .stopped(stop_a[1]), .tray(tray1), .tray_size(size_a[1])
  );
  nucleus_puzzle #(.BLUE_BALLS(0)) u_blue0 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]),
    .stopped(stop_a[2]), .tray(tray2), .tray_size(size_a[2])
  );
  nucleus_puzzle #(.BITS(4), .BLUE_BALLS(6), .RED_BALLS(2), .TRAY_W(8)) u_full (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]),
    .stopped(stop_a[3]), .tray(tray3), .tray_size(size_a[3])
  );

  assign tray_a[0] = tray0;
  assign tray_a[1] = tray1;
  assign tray_a[2] = tray2;
  assign tray_a[3] = {12'b0, tray3};

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];
  logic [24:0] exp_res_q[$];
  int cur   = 0;
  int rises = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: the counter is an integer; a ball exits at the count's lowest zero bit.
  task automatic push_model(input int k, output logic [19:0] m_tray, output int m_size);
    int cnt, b, r, ex, tmp;
    logic col;
    cnt = 0; b = cfg_blue[k]; r = cfg_red[k]; col = 1'b1;
    m_tray = '0; m_size = 0;
    while (1) begin
      if (col ? (b == 0) : (r == 0)) break;
      if (col) b--; else r--;
      ex = 0; tmp = cnt;
      while (tmp % 2 == 1) begin ex++; tmp = tmp / 2; end
      cnt = (cnt + 1) % (1 << cfg_bits[k]);
      if (ex >= cfg_bits[k]) break;
      exp_q.push_back({19'b0, col});
      m_tray[m_size] = col;
      m_size++;
      col = (ex % 2 == 0);
      if (m_size == cfg_tray[k]) break;
    end
    exp_res_q.push_back({5'(m_size), m_tray});
  endtask

  // Monitor: every landed ball and every stop edge is checked against the queues.
  int          mon_size;
  int          prev_size = 0;
  logic        prev_st   = 1'b0;
  logic [19:0] mon_e;
  logic [24:0] mon_r;
  always @(negedge clk) begin
    mon_size = int'(size_a[cur]);
    if (mon_size == prev_size + 1) begin
      if (exp_q.size() == 0) fail_now("unexpected_ball");
      else begin
        mon_e = exp_q.pop_front();
        check("ball_colour", {31'b0, tray_a[cur][mon_size-1]}, mon_e);
      end
    end else if (mon_size != prev_size && mon_size != 0) begin
      fail_now("tray_size_jump");
    end
    if (stop_a[cur] && !prev_st) begin
      rises++;
      if (exp_res_q.size() == 0) fail_now("unexpected_stop");
      else begin
        mon_r = exp_res_q.pop_front();
        check("final_tray", tray_a[cur], mon_r[19:0]);
        check("final_size", mon_size, mon_r[24:20]);
      end
    end
    prev_size = mon_size;
    prev_st   = stop_a[cur];
  end

  task automatic do_reset(input int k);
    @(negedge clk);
    #2 rst_v[k] = 1'b1;
    #1;
    check("rst_stopped", stop_a[k], 0);
    check("rst_tray", tray_a[k], 0);
    check("rst_size", size_a[k], 0);
    @(negedge clk);
    rst_v[k] = 1'b0;
  endtask

  task automatic run_case(input int k, input bit extra);
    logic [19:0] m_tray;
    int m_size, t0, waited, hold;
    do_reset(k);
    cur = k;
    exp_q.delete();
    exp_res_q.delete();
    push_model(k, m_tray, m_size);
    @(negedge clk);
    rises = 0;
    start_v[k] = 1'b1;
    t0 = cyc;
    hold = $urandom_range(1, 3);
    waited = 0;
    while (!stop_a[k] && waited < 3000) begin
      @(negedge clk);
      waited++;
      if (waited >= hold) start_v[k] = extra ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start_v[k] = 1'b0;
    check("stop_in_budget", stop_a[k], 1);
    if (k == 2) check("empty_blue_latency", (cyc - t0) <= 2, 1);
    repeat (3) @(negedge clk);
    start_v[k] = 1'b1;
    repeat (2) @(negedge clk);
    start_v[k] = 1'b0;
    repeat (4) @(negedge clk);
    check("stopped_held", stop_a[k], 1);
    check("held_tray", tray_a[k], m_tray);
    check("held_size", size_a[k], m_size);
    check("single_stop_edge", rises, 1);
    check("balls_all_seen", exp_q.size(), 0);
    check("results_all_seen", exp_res_q.size(), 0);
    if (k == 1) begin
      check("red_starve_tray", tray_a[k], 20'h0003B);
      check("red_starve_size", size_a[k], 6);
    end
    if (k == 2) begin
      check("no_blue_tray", tray_a[k], 0);
      check("no_blue_size", size_a[k], 0);
    end
  endtask

  task automatic reset_mid_run();
    logic [19:0] m_tray;
    int m_size, waited;
    do_reset(0);
    cur = 0;
    exp_q.delete();
    exp_res_q.delete();
    push_model(0, m_tray, m_size);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    waited = 0;
    while (size_a[0] < 5'd3 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("three_landed", size_a[0], 3);
    #2 rst_v[0] = 1'b1;
    #1;
    check("midrun_stopped", stop_a[0], 0);
    check("midrun_tray", tray_a[0], 0);
    check("midrun_size", size_a[0], 0);
    exp_q.delete();
    exp_res_q.delete();
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b0;
    run_case(0, 1'b0);
  endtask

  initial begin
    cfg_bits = '{3, 3, 3, 4};
    cfg_blue = '{10, 10, 0, 6};
    cfg_red  = '{10, 1, 10, 2};
    cfg_tray = '{20, 20, 20, 8};
    for (int k = 0; k < 4; k++) begin
      rst_v[k]   = 1'b1;
      start_v[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      check("por_stopped", stop_a[k], 0);
      check("por_tray", tray_a[k], 0);
      check("por_size", size_a[k], 0);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst_v[k] = 1'b0;

    repeat (100) @(negedge clk);
    check("idle_stopped", stop_a[0], 0);
    check("idle_tray", tray_a[0], 0);
    check("idle_size", size_a[0], 0);

    for (int k = 0; k < 4; k++) run_case(k, 1'b0);
    run_case(0, 1'b1);
    reset_mid_run();
    for (int i = 0; i < 4; i++) run_case($urandom_range(0, 3), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
